hsk_multi_rx: RTL
=================

// Module: hsk_multi_rx
// PURPOSE
//   Multi-channel receive side of a 4-phase req/ack bundled-data handshake. CH sources,
//   each asynchronous to clk, present data_i with req_i held high; the block synchronises
//   each req_i, round-robin arbitrates pending channels and captures one word into a
//   single-entry valid/ready output register. It then returns ack_o to the granted source.
//   It sits at the clk-domain boundary of every multi-source CDC link and replaces
//   per-link point-to-point synchronisers.
// PARAMETERS
//   CH           4    number of source channels (>=2)
//   BUS_WIDTH    8    data bits per channel
//   SYNC_STAGES  2    flops in each req_i synchroniser (>=2)
//   TO_CYCLES    255  ACK-phase timeout threshold (only with HSK_RX_TIMEOUT_EN)
// PORTS
//   clk          in   1               sole clock; all state on posedge clk
//   rst_n        in   1               asynchronous, active-low reset
//   req_i        in   CH              per-channel request, asynchronous to clk
//   data_i       in   CH*BUS_WIDTH    channel c at [c*BUS_WIDTH +: BUS_WIDTH]; stable while req_i[c]=1
//   ack_o        out  CH              per-channel acknowledge, registered
//   m_valid      out  1               output word valid
//   m_ready      in   1               downstream accepts the word when m_valid && m_ready
//   m_data       out  BUS_WIDTH       captured word
//   m_ch         out  $clog2(CH)      source channel of m_data
//   err_timeout  out  CH              sticky per-channel timeout flag
// BEHAVIOUR
//   - Reset values: ack_o=0, m_valid=0, m_data=0, m_ch=0, err_timeout=0. Sync flops=0,
//     all channels IDLE, round-robin pointer=0. Assertion mid-transfer discards the held
//     word and any pending grant. Sources see ack_o drop and must return req_i low.
//   - req_s[c] is the SYNC_STAGES-flop synchronised version of req_i[c].
//     data_i is sampled only on grant, never through a synchroniser.
//   - Per-channel FSM:
//     IDLE -> PEND when req_s=1.
//     PEND -> ACK when granted; data_i[c] is captured and ack_o[c]<=1 on the same edge.
//     PEND -> IDLE when req_s=0 (protocol violation; no word emitted).
//     ACK -> IDLE when req_s=0; ack_o[c]<=0 on that edge.
//   - Slot free = !m_valid || m_ready. Grant fires in any cycle with a free slot and at
//     least one PEND channel. Load and drain in the same cycle are legal: full throughput.
//   - Arbitration is round-robin. Search starts at the pointer; after a grant the pointer
//     moves to grant+1, wrapping at CH. Only one grant per cycle.
//   - Latency: req_i sampled high at edge 0 -> m_valid=1 and ack_o=1 after edge
//     SYNC_STAGES+2, if the slot is free and no other channel wins. req_i low -> ack_o low
//     after edge SYNC_STAGES+1.
//   - m_data and m_ch hold while m_valid && !m_ready.
//   - A channel cannot re-request until its ACK phase closes. This guarantees at most one
//     word per 4-phase cycle.
// CONFIGURATION
//   HSK_RX_TIMEOUT_EN defined:
//     - Each channel has a counter of width $clog2(TO_CYCLES+1), cleared on entry to ACK.
//     - The counter increments each cycle in ACK while req_s=1 and saturates at TO_CYCLES.
//     - When it reaches TO_CYCLES, err_timeout[c] is set and stays set until rst_n.
//     - The FSM is unaffected.
//   HSK_RX_TIMEOUT_EN undefined: err_timeout is tied to 0 and no counters exist.
// STRUCTURE
//   - hsk_pkg: state encoding (IDLE/PEND/ACK localparams) and helper for clog2 widths.
//   - Sub-module hsk_sync_cell: SYNC_STAGES-deep reset-to-0 flop chain, 1 bit,
//     instantiated CH times.
//   - Top level holds the FSMs, the arbiter, the output register and the timeout logic.
// TESTING
//   - Single channel, CH=4, SYNC_STAGES=2: req_i[1]=1 with data 8'hA5, m_ready=1 ->
//     m_valid=1, m_data=A5, m_ch=1, ack_o[1]=1 after edge 4. req_i low -> ack_o[1]=0
//     after edge 3.
//   - All 4 channels request together, m_ready=1 -> grants in order 0,1,2,3 on consecutive
//     cycles. Re-request of ch0 while ch3 is pending -> ch3 first.
//   - Backpressure: m_ready=0 with m_valid=1 -> m_data/m_ch stable. Other channels stay
//     PEND with ack_o=0. m_ready=1 -> next word loads on the same edge as the drain.
//   - Protocol violation: req_i[2] pulses high 3 cycles then low before grant
//     (m_ready=0) -> no word from ch2 and ack_o[2] never asserts.
//   - Reset mid-transfer: rst_n=0 while m_valid=1 and ack_o[0]=1 -> all outputs 0
//     immediately (async). After release, a new request completes normally.
//   - HSK_RX_TIMEOUT_EN with TO_CYCLES=10: ch0 holds req_i high after ack ->
//     err_timeout[0]=1 after 10 ACK cycles and stays 1 after req drops.

Source files
------------

// File: rtl/hsk_pkg.sv
// Shared definitions for the multi-channel req/ack receiver: per-channel state
// encoding and a width helper for index and counter vectors.
package hsk_pkg;

   typedef logic [1:0] hsk_state_t;

   localparam hsk_state_t ST_IDLE = 2'd0;
   localparam hsk_state_t ST_PEND = 2'd1;
   localparam hsk_state_t ST_ACK  = 2'd2;

   // Bits needed to index n items; never less than 1.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hsk_sync_cell.sv
// Single-bit reset-to-0 synchroniser chain of STAGES flops.
module hsk_sync_cell #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the asynchronous input one stage per clock.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // Synchroniser flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hsk_multi_rx.sv
// Multi-channel 4-phase req/ack receiver: synchronises each req_i, round-robin
// arbitrates pending channels into one valid/ready output register and returns
// ack_o to the granted source.
// Optional feature: define HSK_RX_TIMEOUT_EN to enable per-channel ACK-phase
// timeout counters driving the sticky err_timeout flags.
module hsk_multi_rx
   import hsk_pkg::*;
#(
   parameter  int unsigned CH          = 4,
   parameter  int unsigned BUS_WIDTH   = 8,
   parameter  int unsigned SYNC_STAGES = 2,
   parameter  int unsigned TO_CYCLES   = 255,
   localparam int unsigned CH_W        = clog2_min1(CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [CH-1:0]           req_i,
   input  logic [CH*BUS_WIDTH-1:0] data_i,
   output logic [CH-1:0]           ack_o,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [BUS_WIDTH-1:0]    m_data,
   output logic [CH_W-1:0]         m_ch,
   output logic [CH-1:0]           err_timeout
);

   logic [CH-1:0]              req_s;
   hsk_state_t [CH-1:0]        state_q, state_d;
   logic [CH_W-1:0]            ptr_q, ptr_d;
   logic [CH-1:0]              ack_q, ack_d;
   logic                       m_valid_q, m_valid_d;
   logic [BUS_WIDTH-1:0]       m_data_q, m_data_d;
   logic [CH_W-1:0]            m_ch_q, m_ch_d;
   logic                       slot_free;
   logic                       gnt_vld;
   logic [CH_W-1:0]            gnt_idx;
   logic [CH_W-1:0]            cand;

   for (genvar g = 0; g < CH; g++) begin : g_sync
      hsk_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (req_i[g]),
         .q     (req_s[g])
      );
   end

   // Round-robin search from the pointer; a channel is eligible only while still requesting.
   always_comb begin
      gnt_vld   = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      slot_free = !m_valid_q || m_ready;
      for (int i = 0; i < int'(CH); i++) begin
         cand = CH_W'((int'(ptr_q) + i) % int'(CH));
         if (!gnt_vld && slot_free && state_q[cand] == ST_PEND && req_s[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // Per-channel state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < int'(CH); c++) state_q[c] <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Per-channel next state: request, grant, and release of the 4-phase cycle.
   always_comb begin
      state_d = state_q;
      for (int c = 0; c < int'(CH); c++) begin
         case (state_q[c])
            ST_IDLE: if (req_s[c]) state_d[c] = ST_PEND;
            ST_PEND: begin
               if (gnt_vld && gnt_idx == CH_W'(c)) state_d[c] = ST_ACK;
               else if (!req_s[c])                 state_d[c] = ST_IDLE;
            end
            ST_ACK:  if (!req_s[c]) state_d[c] = ST_IDLE;
            default: state_d[c] = ST_IDLE;
         endcase
      end
   end

   // Output next values: ack follows ACK state, output register loads on grant.
   always_comb begin
      ack_d     = '0;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_ch_d    = m_ch_q;
      ptr_d     = ptr_q;
      for (int c = 0; c < int'(CH); c++) begin
         ack_d[c] = (state_d[c] == ST_ACK);
         if (gnt_vld && gnt_idx == CH_W'(c)) m_data_d = data_i[c*BUS_WIDTH +: BUS_WIDTH];
      end
      if (gnt_vld) begin
         m_valid_d = 1'b1;
         m_ch_d    = gnt_idx;
         ptr_d     = (gnt_idx == CH_W'(CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   // Output, acknowledge and arbitration-pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_ch_q    <= '0;
         ptr_q     <= '0;
      end else begin
         ack_q     <= ack_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_ch_q    <= m_ch_d;
         ptr_q     <= ptr_d;
      end
   end

   assign ack_o   = ack_q;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_ch    = m_ch_q;

`ifdef HSK_RX_TIMEOUT_EN
   localparam int unsigned TO_W = clog2_min1(TO_CYCLES + 1);

   logic [CH-1:0][TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [CH-1:0]           err_q, err_d;

   // ACK-phase counters: clear on entry, count while req stays high, saturate.
   always_comb begin
      to_cnt_d = to_cnt_q;
      err_d    = err_q;
      for (int c = 0; c < int'(CH); c++) begin
         if (state_q[c] != ST_ACK && state_d[c] == ST_ACK) begin
            to_cnt_d[c] = '0;
         end else if (state_q[c] == ST_ACK && req_s[c] && to_cnt_q[c] != TO_W'(TO_CYCLES)) begin
            to_cnt_d[c] = to_cnt_q[c] + TO_W'(1);
         end
         if (state_q[c] == ST_ACK && to_cnt_d[c] == TO_W'(TO_CYCLES)) err_d[c] = 1'b1;
      end
   end

   // Timeout counters and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
         err_q    <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
         err_q    <= err_d;
      end
   end

   assign err_timeout = err_q;
`else
   assign err_timeout = '0;
`endif

endmodule
